chip: RTL and testbench

Behavioural DRAM device model: a single x`DEVICE_WIDTH` chip made of `2**BGWIDTH` bank groups of `2**BAWIDTH` banks each. Every bank is an independent row × column storage array with its own read/write select, address and data lanes, so all banks may be accessed in the same cycle. It sits below the rank/channel model, which performs command decoding and drives each bank's lanes directly.

---
 rtl/chip.sv | 74 +++++++
 tb/tb_chip.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/chip.sv
// Behavioural DRAM device: BANKGROUPS x BANKSPERGROUP independent banks, each a
// row x column array with one registered read or one write per clock.
module chip_bank #(
    parameter int COLWIDTH     = 10,
    parameter int DEVICE_WIDTH = 4,
    parameter int CHWIDTH      = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rd_o_wr,
    input  logic [DEVICE_WIDTH-1:0] dqin,
    input  logic [CHWIDTH-1:0]      row,
    input  logic [COLWIDTH-1:0]     column,
    output logic [DEVICE_WIDTH-1:0] dqout
);
    localparam int DEPTH = 2**(CHWIDTH+COLWIDTH);

    // Array is deliberately not reset so stored data survives rst_n pulses.
    logic [DEVICE_WIDTH-1:0]     r_mem [DEPTH];
    logic [DEVICE_WIDTH-1:0]     r_dq;
    logic [CHWIDTH+COLWIDTH-1:0] w_addr;

    assign w_addr = {row, column};

    always_ff @(posedge clk) begin
        if (rst_n && rd_o_wr)
            r_mem[w_addr] <= dqin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_dq <= '0;
        else if (!rd_o_wr)
            r_dq <= r_mem[w_addr];
    end

    assign dqout = r_dq;
endmodule

module chip #(
    parameter int BGWIDTH      = 2,
    parameter int BAWIDTH      = 2,
    parameter int COLWIDTH     = 10,
    parameter int DEVICE_WIDTH = 4,
    parameter int CHWIDTH      = 5,
    localparam int BANKGROUPS    = 2**BGWIDTH,
    localparam int BANKSPERGROUP = 2**BAWIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rd_o_wr [BANKGROUPS-1:0][BANKSPERGROUP-1:0],
    input  logic [DEVICE_WIDTH-1:0] dqin    [BANKGROUPS-1:0][BANKSPERGROUP-1:0],
    output logic [DEVICE_WIDTH-1:0] dqout   [BANKGROUPS-1:0][BANKSPERGROUP-1:0],
    input  logic [CHWIDTH-1:0]      row     [BANKGROUPS-1:0][BANKSPERGROUP-1:0],
    input  logic [COLWIDTH-1:0]     column  [BANKGROUPS-1:0][BANKSPERGROUP-1:0]
);
    for (genvar g = 0; g < BANKGROUPS; g++) begin : g_grp
        for (genvar b = 0; b < BANKSPERGROUP; b++) begin : g_bank
            chip_bank #(
                .COLWIDTH    (COLWIDTH),
                .DEVICE_WIDTH(DEVICE_WIDTH),
                .CHWIDTH     (CHWIDTH)
            ) u_bank (
                .clk    (clk),
                .rst_n  (rst_n),
                .rd_o_wr(rd_o_wr[g][b]),
                .dqin   (dqin[g][b]),
                .row    (row[g][b]),
                .column (column[g][b]),
                .dqout  (dqout[g][b])
            );
        end
    end
endmodule

// File: tb/tb_chip.sv
// Scoreboard bench for chip: predicted dqout words are queued when a cycle is
// driven and compared after the edge that should produce them.
module tb_chip;
    localparam int NG = 4, NB = 4;

    logic       clk, rst_n;
    logic       rd_o_wr [NG-1:0][NB-1:0];
    logic [3:0] dqin    [NG-1:0][NB-1:0];
    logic [3:0] dqout   [NG-1:0][NB-1:0];
    logic [4:0] row     [NG-1:0][NB-1:0];
    logic [9:0] column  [NG-1:0][NB-1:0];

    chip dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_o_wr(rd_o_wr),
        .dqin   (dqin),
        .dqout  (dqout),
        .row    (row),
        .column (column)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         g;
        int         b;
        logic [3:0] v;
        string      tag;
    } exp_t;

    exp_t       sbq[$];
    logic [3:0] mdl [int];
    logic [3:0] shd [NG][NB];
    bit         shk [NG][NB];
    int         n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int key(input int g, input int b, input int r, input int c);
        return ((g*NB + b) << 15) | (r << 10) | c;
    endfunction

    task automatic idle();
        for (int g = 0; g < NG; g++)
            for (int b = 0; b < NB; b++) begin
                rd_o_wr[g][b] = 1'b0;
                dqin[g][b]    = '0;
                row[g][b]     = '0;
                column[g][b]  = '0;
            end
    endtask

    task automatic set(input int g, input int b, input bit wr, input int r, input int c, input logic [3:0] d);
        rd_o_wr[g][b] = wr;
        row[g][b]     = 5'(r);
        column[g][b]  = 10'(c);
        dqin[g][b]    = d;
    endtask

    task automatic chk_all_zero(input string tag);
        for (int g = 0; g < NG; g++)
            for (int b = 0; b < NB; b++) begin
                chk($sformatf("%s[%0d][%0d]", tag, g, b), dqout[g][b], 4'h0);
                shd[g][b] = 4'h0;
                shk[g][b] = 1'b1;
            end
    endtask

    // Predict every bank's dqout for this edge, clock it, then drain the queue.
    task automatic step(input string tag);
        exp_t e;
        for (int g = 0; g < NG; g++)
            for (int b = 0; b < NB; b++) begin
                int k;
                k = key(g, b, int'(row[g][b]), int'(column[g][b]));
                if (!rst_n) begin
                    shd[g][b] = 4'h0;
                    shk[g][b] = 1'b1;
                end else if (rd_o_wr[g][b]) begin
                    mdl[k] = dqin[g][b];
                end else if (mdl.exists(k)) begin
                    shd[g][b] = mdl[k];
                    shk[g][b] = 1'b1;
                end else begin
                    shk[g][b] = 1'b0;
                end
                if (shk[g][b])
                    sbq.push_back('{g, b, shd[g][b], $sformatf("%s[%0d][%0d]", tag, g, b)});
            end
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.tag, dqout[e.g][e.b], e.v);
        end
    endtask

    logic [3:0] burst [8];

    initial begin
        rst_n = 1'b1;
        idle();
        for (int g = 0; g < NG; g++)
            for (int b = 0; b < NB; b++) shk[g][b] = 1'b0;

        // Asynchronous reset, checked before the first clock edge.
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_async");
        step("rst_hold");
        step("rst_hold");
        rst_n = 1'b1;
        chk_all_zero("rst_release");

        // Burst write then read on bank [1][1], row 1 cols 0..7.
        for (int i = 0; i < 8; i++) begin
            burst[i] = 4'($urandom_range(0, 15));
            idle();
            set(1, 1, 1'b1, 1, i, burst[i]);
            step("bwr");
        end
        for (int i = 0; i < 8; i++) begin
            idle();
            set(1, 1, 1'b0, 1, i, 4'h0);
            step("brd");
            chk($sformatf("burst%0d", i), dqout[1][1], burst[i]);
        end

        // Concurrent distinct writes to row 0 col 0 of all banks, then read all.
        idle();
        for (int g = 0; g < NG; g++)
            for (int b = 0; b < NB; b++) set(g, b, 1'b1, 0, 0, 4'(g*4 + b));
        step("cwr");
        idle();
        step("crd");
        for (int g = 0; g < NG; g++)
            for (int b = 0; b < NB; b++)
                chk($sformatf("conc[%0d][%0d]", g, b), dqout[g][b], 4'(g*4 + b));

        // Bank isolation: others hold known data at row 1 col 3.
        idle();
        for (int g = 0; g < NG; g++)
            for (int b = 0; b < NB; b++)
                if (!(g == 1 && b == 1)) set(g, b, 1'b1, 1, 3, 4'((g*4 + b) ^ 5));
        step("iso_pre");
        idle();
        for (int g = 0; g < NG; g++)
            for (int b = 0; b < NB; b++) set(g, b, 1'b0, 1, 3, 4'h0);
        set(1, 1, 1'b1, 1, 3, 4'hA);
        step("iso_wr");
        idle();
        set(1, 1, 1'b0, 1, 3, 4'h0);
        step("iso_rd");
        chk("iso_11", dqout[1][1], 4'hA);

        // Read 0x5 then write elsewhere in the same bank: dqout must hold.
        idle();
        set(2, 1, 1'b1, 4, 9, 4'h5);
        step("hold_setup");
        idle();
        set(2, 1, 1'b0, 4, 9, 4'h0);
        step("hold_rd");
        idle();
        set(2, 1, 1'b1, 7, 100, 4'hC);
        step("hold_wr");
        chk("hold_21", dqout[2][1], 4'h5);
        idle();
        set(2, 1, 1'b0, 7, 100, 4'h0);
        step("wr_then_rd");

        // Address extremes on [3][3], then a reset pulse that also tries to write.
        idle();
        set(3, 3, 1'b1, 31, 1023, 4'hF);
        step("ext_wr_hi");
        idle();
        set(3, 3, 1'b1, 0, 0, 4'h1);
        step("ext_wr_lo");
        idle();
        set(3, 3, 1'b0, 0, 0, 4'h0);
        step("ext_rd_pre");
        rst_n = 1'b0;
        set(3, 3, 1'b1, 31, 1023, 4'h7);
        #1 chk_all_zero("rst_pulse");
        step("rst_blk");
        rst_n = 1'b1;
        idle();
        set(3, 3, 1'b0, 31, 1023, 4'h0);
        step("ext_rd_hi");
        chk("persist_hi", dqout[3][3], 4'hF);
        idle();
        set(3, 3, 1'b0, 0, 0, 4'h0);
        step("ext_rd_lo");
        chk("persist_lo", dqout[3][3], 4'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
